// File: rtl/uarc_pkg.sv
// rtl/uarc_pkg.sv - shared UARC types: receiver FSM states, FIFO entry, request priority
package uarc_pkg;

  localparam int UARC_WORD_MAG   = 5;
  localparam int UARC_WORD_WIDTH = 1 << UARC_WORD_MAG;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } uarc_rx_state_t;

  typedef struct packed {
    logic                       last;
    logic [UARC_WORD_WIDTH-1:0] data;
  } uarc_entry_t;

  // Enum order mirrors bus priority: kill > incept > send > stream.
  typedef enum logic [2:0] {
    REQ_NONE   = 3'd0,
    REQ_KILL   = 3'd1,
    REQ_INCEPT = 3'd2,
    REQ_SEND   = 3'd3,
    REQ_STREAM = 3'd4
  } uarc_req_t;

  function automatic uarc_req_t uarc_arbitrate(input logic kill, input logic incept,
                                               input logic send, input logic stream);
    if (kill)        return REQ_KILL;
    else if (incept) return REQ_INCEPT;
    else if (send)   return REQ_SEND;
    else if (stream) return REQ_STREAM;
    else             return REQ_NONE;
  endfunction

endpackage

// File: rtl/uarc_bus_receiver_if.sv
// rtl/uarc_bus_receiver_if.sv - sender-to-receiver UARC bus signals and acks
interface uarc_bus_receiver_if #(
  parameter int WORD_WIDTH = 32
);
  logic                  enable;
  logic                  kill;
  logic                  incept;
  logic                  send;
  logic                  stream;
  logic [WORD_WIDTH-1:0] data;
  logic [WORD_WIDTH-1:0] self_permission;
  logic [WORD_WIDTH-1:0] self_address;
  logic [WORD_WIDTH-1:0] incept_permission;
  logic [WORD_WIDTH-1:0] incept_address;
  logic                  kill_ack;
  logic                  incept_ack;
  logic                  send_ack;
  logic                  stream_ack;

  modport master (
    output enable, kill, incept, send, stream, data,
           self_permission, self_address, incept_permission, incept_address,
    input  kill_ack, incept_ack, send_ack, stream_ack
  );

  modport slave (
    input  enable, kill, incept, send, stream, data,
           self_permission, self_address, incept_permission, incept_address,
    output kill_ack, incept_ack, send_ack, stream_ack
  );
endinterface

// File: rtl/uarc_fifo.sv
// rtl/uarc_fifo.sv - synchronous FIFO with flush, registered count, full/empty
module uarc_fifo #(
  parameter int WIDTH      = 33,
  parameter int ADDR_WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  do_push, do_pop;

  assign full      = (count_q == (ADDR_WIDTH+1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign head_data = mem_q[rd_ptr_q];
  // Flush discards any same-cycle push or pop.
  assign do_push   = push & ~full & ~flush;
  assign do_pop    = pop & ~empty & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (ADDR_WIDTH+1)'(1);
        2'b01:   count_d = count_q - (ADDR_WIDTH+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end
endmodule

// File: rtl/uarc_bus_receiver.sv
// rtl/uarc_bus_receiver.sv - UARC bus receiving endpoint: acks, incept/kill FSM, context, word FIFO
module uarc_bus_receiver
  import uarc_pkg::*;
#(
  parameter  int WORD_MAG        = 5,
  parameter  int FIFO_ADDR_WIDTH = 4,
  localparam int WORD_WIDTH      = 1 << WORD_MAG
) (
  input  logic                  clk,
  input  logic                  reset,
  uarc_bus_receiver_if.slave    bus,
  output logic                  active,
  output logic [WORD_WIDTH-1:0] ctx_permission,
  output logic [WORD_WIDTH-1:0] ctx_address,
  output logic [WORD_WIDTH-1:0] ret_permission,
  output logic [WORD_WIDTH-1:0] ret_address,
  output logic                  out_valid,
  output logic [WORD_WIDTH-1:0] out_data,
  output logic                  out_last,
  input  logic                  out_pop,
  output logic                  killed
);
  typedef struct packed {
    logic                  last;
    logic [WORD_WIDTH-1:0] data;
  } entry_t;

  uarc_rx_state_t        state_q, state_d;
  uarc_req_t             req;
  logic                  killed_q;
  logic [WORD_WIDTH-1:0] ctx_perm_q, ctx_addr_q, ret_perm_q, ret_addr_q;
  logic                  fifo_full, fifo_empty, can_push;
  logic                  kill_ack, incept_ack, send_ack, stream_ack;
  entry_t                push_entry, head_entry;

  always_comb begin
    req        = bus.enable ? uarc_arbitrate(bus.kill, bus.incept, bus.send, bus.stream) : REQ_NONE;
    can_push   = (state_q == ACTIVE) & ~fifo_full;
    kill_ack   = (req == REQ_KILL);
    incept_ack = (req == REQ_INCEPT) & (state_q == IDLE);
    send_ack   = (req == REQ_SEND) & can_push;
    stream_ack = (req == REQ_STREAM) & can_push;
    state_d    = state_q;
    if (kill_ack)        state_d = IDLE;
    else if (incept_ack) state_d = ACTIVE;
    push_entry = '{last: send_ack, data: bus.data};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      killed_q   <= 1'b0;
      ctx_perm_q <= '0;
      ctx_addr_q <= '0;
      ret_perm_q <= '0;
      ret_addr_q <= '0;
    end else begin
      state_q  <= state_d;
      killed_q <= kill_ack;
      if (kill_ack) begin
        ctx_perm_q <= '0;
        ctx_addr_q <= '0;
        ret_perm_q <= '0;
        ret_addr_q <= '0;
      end else if (incept_ack) begin
        ctx_perm_q <= bus.incept_permission;
        ctx_addr_q <= bus.incept_address;
        ret_perm_q <= bus.self_permission;
        ret_addr_q <= bus.self_address;
      end
    end
  end

  uarc_fifo #(
    .WIDTH      (WORD_WIDTH + 1),
    .ADDR_WIDTH (FIFO_ADDR_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (kill_ack | incept_ack),
    .push      (send_ack | stream_ack),
    .push_data (push_entry),
    .pop       (out_pop),
    .head_data (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bus.kill_ack   = kill_ack;
  assign bus.incept_ack = incept_ack;
  assign bus.send_ack   = send_ack;
  assign bus.stream_ack = stream_ack;

  assign active         = (state_q == ACTIVE);
  assign killed         = killed_q;
  assign ctx_permission = ctx_perm_q;
  assign ctx_address    = ctx_addr_q;
  assign ret_permission = ret_perm_q;
  assign ret_address    = ret_addr_q;
  // Head is masked while empty so stale RAM contents never appear on the outputs.
  assign out_valid      = ~fifo_empty;
  assign out_data       = out_valid ? head_entry.data : '0;
  assign out_last       = out_valid & head_entry.last;
endmodule

// File: tb/tb_uarc_bus_receiver.sv
// tb/tb_uarc_bus_receiver.sv - directed self-checking bench for uarc_bus_receiver
module tb_uarc_bus_receiver;
  logic        clk = 1'b0;
  logic        reset;
  logic        active, out_valid, out_last, out_pop, killed;
  logic [31:0] ctx_permission, ctx_address, ret_permission, ret_address, out_data;
  int          n_cmp = 0;
  int          n_err = 0;

  uarc_bus_receiver_if #(.WORD_WIDTH(32)) bus ();

  uarc_bus_receiver #(.WORD_MAG(5), .FIFO_ADDR_WIDTH(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus),
    .active         (active),
    .ctx_permission (ctx_permission),
    .ctx_address    (ctx_address),
    .ret_permission (ret_permission),
    .ret_address    (ret_address),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_last       (out_last),
    .out_pop        (out_pop),
    .killed         (killed)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobes(input logic en, input logic k, input logic i, input logic s, input logic st);
    bus.enable = en; bus.kill = k; bus.incept = i; bus.send = s; bus.stream = st;
    #2;
  endtask

  task automatic test_reset();
    reset = 1'b1; out_pop = 1'b0;
    bus.data = '0; bus.self_permission = '0; bus.self_address = '0;
    bus.incept_permission = '0; bus.incept_address = '0;
    strobes(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    reset = 1'b0;
    if ({active, killed, out_valid, out_last} !== 4'b0000) begin
      n_err++; $display("FAIL reset_flags got %b exp 0000", {active, killed, out_valid, out_last});
    end
    n_cmp++;
    if ({ctx_permission, ctx_address, ret_permission, ret_address, out_data} !== '0) begin
      n_err++; $display("FAIL reset_regs got %h %h %h %h %h exp all 0", ctx_permission, ctx_address, ret_permission, ret_address, out_data);
    end
    n_cmp++;
    strobes(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    if ({bus.kill_ack, bus.incept_ack, bus.send_ack, bus.stream_ack} !== 4'b0000) begin
      n_err++; $display("FAIL idle_send_ack got %b exp 0000", {bus.kill_ack, bus.incept_ack, bus.send_ack, bus.stream_ack});
    end
    n_cmp++;
    strobes(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_incept();
    bus.incept_permission = 32'hA5; bus.incept_address = 32'h10;
    bus.self_permission = 32'h77; bus.self_address = 32'h3;
    strobes(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    if ({bus.kill_ack, bus.incept_ack, bus.send_ack, bus.stream_ack} !== 4'b0100) begin
      n_err++; $display("FAIL incept_ack got %b exp 0100", {bus.kill_ack, bus.incept_ack, bus.send_ack, bus.stream_ack});
    end
    n_cmp++;
    tick();
    strobes(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    if ({active, ctx_permission, ctx_address, ret_permission, ret_address} !== {1'b1, 32'hA5, 32'h10, 32'h77, 32'h3}) begin
      n_err++; $display("FAIL incept_ctx got act=%b %h %h %h %h exp 1 a5 10 77 3", active, ctx_permission, ctx_address, ret_permission, ret_address);
    end
    n_cmp++;
  endtask

  task automatic test_send_stream();
    logic [3:0]  exp_ack [3] = '{4'b0001, 4'b0001, 4'b0010};
    logic [31:0] exp_dat [3] = '{32'h11, 32'h22, 32'h33};
    for (int i = 0; i < 3; i++) begin
      bus.data = exp_dat[i];
      strobes(1'b1, 1'b0, 1'b0, exp_ack[i][1], exp_ack[i][0]);
      if ({bus.kill_ack, bus.incept_ack, bus.send_ack, bus.stream_ack} !== exp_ack[i]) begin
        n_err++; $display("FAIL push_ack[%0d] got %b exp %b", i, {bus.kill_ack, bus.incept_ack, bus.send_ack, bus.stream_ack}, exp_ack[i]);
      end
      n_cmp++;
      tick();
    end
    strobes(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    out_pop = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if ({out_valid, out_last, out_data} !== {1'b1, (i == 2), exp_dat[i]}) begin
        n_err++; $display("FAIL pop_head[%0d] got v=%b l=%b d=%h exp v=1 l=%0d d=%h", i, out_valid, out_last, out_data, (i == 2), exp_dat[i]);
      end
      n_cmp++;
      tick();
    end
    out_pop = 1'b0;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL drained_valid got %b exp 0", out_valid);
    end
    n_cmp++;
  endtask

  task automatic test_send_over_stream();
    bus.data = 32'h66;
    strobes(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    if ({bus.kill_ack, bus.incept_ack, bus.send_ack, bus.stream_ack} !== 4'b0010) begin
      n_err++; $display("FAIL send_over_stream got %b exp 0010", {bus.kill_ack, bus.incept_ack, bus.send_ack, bus.stream_ack});
    end
    n_cmp++;
    tick();
    strobes(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    if ({out_valid, out_last, out_data} !== {2'b11, 32'h66}) begin
      n_err++; $display("FAIL send_over_stream_head got v=%b l=%b d=%h exp 1 1 66", out_valid, out_last, out_data);
    end
    n_cmp++;
    out_pop = 1'b1; tick(); out_pop = 1'b0;
  endtask

  task automatic test_full();
    for (int i = 0; i < 16; i++) begin
      bus.data = i;
      strobes(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      if (bus.stream_ack !== 1'b1) begin
        n_err++; $display("FAIL fill_ack[%0d] got %b exp 1", i, bus.stream_ack);
      end
      n_cmp++;
      tick();
    end
    bus.data = 32'hFF; out_pop = 1'b1;
    strobes(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    if (bus.send_ack !== 1'b0) begin
      n_err++; $display("FAIL full_send_ack got %b exp 0", bus.send_ack);
    end
    n_cmp++;
    tick();
    out_pop = 1'b0; #2;
    if (bus.send_ack !== 1'b1) begin
      n_err++; $display("FAIL freed_send_ack got %b exp 1", bus.send_ack);
    end
    n_cmp++;
    tick(); #2;
    if (bus.send_ack !== 1'b0) begin
      n_err++; $display("FAIL refull_send_ack got %b exp 0", bus.send_ack);
    end
    n_cmp++;
    strobes(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    out_pop = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if ({out_valid, out_last, out_data} !== {1'b1, (k == 15), (k == 15) ? 32'hFF : 32'(k + 1)}) begin
        n_err++; $display("FAIL full_drain[%0d] got v=%b l=%b d=%h", k, out_valid, out_last, out_data);
      end
      n_cmp++;
      tick();
    end
    out_pop = 1'b0;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL full_drained_valid got %b exp 0", out_valid);
    end
    n_cmp++;
  endtask

  task automatic test_kill();
    for (int i = 0; i < 5; i++) begin
      bus.data = 32'h100 + i;
      strobes(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
    end
    out_pop = 1'b1;
    strobes(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    if ({bus.kill_ack, bus.incept_ack, bus.send_ack, bus.stream_ack} !== 4'b1000) begin
      n_err++; $display("FAIL kill_ack got %b exp 1000", {bus.kill_ack, bus.incept_ack, bus.send_ack, bus.stream_ack});
    end
    n_cmp++;
    tick();
    out_pop = 1'b0;
    strobes(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    if ({active, out_valid, killed} !== 3'b001) begin
      n_err++; $display("FAIL kill_state got act=%b v=%b killed=%b exp 0 0 1", active, out_valid, killed);
    end
    n_cmp++;
    if ({ctx_permission, ctx_address, ret_permission, ret_address} !== '0) begin
      n_err++; $display("FAIL kill_ctx got %h %h %h %h exp all 0", ctx_permission, ctx_address, ret_permission, ret_address);
    end
    n_cmp++;
    tick();
    if (killed !== 1'b0) begin
      n_err++; $display("FAIL killed_pulse got %b exp 0", killed);
    end
    n_cmp++;
  endtask

  task automatic test_incept_while_active();
    bus.incept_permission = 32'h5A; bus.incept_address = 32'h20;
    strobes(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    for (int c = 0; c < 2; c++) begin
      #2;
      if ({active, bus.incept_ack} !== 2'b10) begin
        n_err++; $display("FAIL active_incept[%0d] got act=%b ack=%b exp 1 0", c, active, bus.incept_ack);
      end
      n_cmp++;
      tick();
    end
    bus.incept_permission = 32'hC3;
    strobes(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    if ({bus.kill_ack, bus.incept_ack} !== 2'b10) begin
      n_err++; $display("FAIL kill_over_incept got %b exp 10", {bus.kill_ack, bus.incept_ack});
    end
    n_cmp++;
    tick();
    strobes(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    if (bus.incept_ack !== 1'b1) begin
      n_err++; $display("FAIL incept_after_kill got %b exp 1", bus.incept_ack);
    end
    n_cmp++;
    tick();
    strobes(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    if ({active, ctx_permission} !== {1'b1, 32'hC3}) begin
      n_err++; $display("FAIL reincept_ctx got act=%b perm=%h exp 1 c3", active, ctx_permission);
    end
    n_cmp++;
  endtask

  task automatic test_enable_low();
    for (int i = 0; i < 2; i++) begin
      bus.data = 32'h44 + 32'(i * 17);
      strobes(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
    end
    bus.data = 32'hDEAD;
    for (int c = 0; c < 3; c++) begin
      strobes(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      if ({bus.kill_ack, bus.incept_ack, bus.send_ack, bus.stream_ack} !== 4'b0000) begin
        n_err++; $display("FAIL disabled_acks[%0d] got %b exp 0000", c, {bus.kill_ack, bus.incept_ack, bus.send_ack, bus.stream_ack});
      end
      n_cmp++;
      tick();
    end
    strobes(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    if ({active, killed, out_valid, out_data, ctx_permission} !== {3'b101, 32'h44, 32'hC3}) begin
      n_err++; $display("FAIL disabled_state got act=%b k=%b v=%b d=%h perm=%h exp 1 0 1 44 c3", active, killed, out_valid, out_data, ctx_permission);
    end
    n_cmp++;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin
      bus.data = 32'h200 + i;
      strobes(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
    end
    bus.data = 32'h999;
    reset = 1'b1;
    strobes(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    reset = 1'b0;
    strobes(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    if ({active, killed, out_valid, out_last, out_data} !== {4'b0000, 32'h0}) begin
      n_err++; $display("FAIL midreset_flags got act=%b k=%b v=%b l=%b d=%h exp all 0", active, killed, out_valid, out_last, out_data);
    end
    n_cmp++;
    if ({ctx_permission, ctx_address, ret_permission, ret_address} !== '0) begin
      n_err++; $display("FAIL midreset_ctx got %h %h %h %h exp all 0", ctx_permission, ctx_address, ret_permission, ret_address);
    end
    n_cmp++;
    if ({bus.kill_ack, bus.incept_ack, bus.send_ack, bus.stream_ack} !== 4'b0000) begin
      n_err++; $display("FAIL midreset_send_ack got %b exp 0000", {bus.kill_ack, bus.incept_ack, bus.send_ack, bus.stream_ack});
    end
    n_cmp++;
    tick();
    if ({killed, out_valid} !== 2'b00) begin
      n_err++; $display("FAIL postreset_killed got k=%b v=%b exp 0 0", killed, out_valid);
    end
    n_cmp++;
    strobes(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_incept();
    test_send_stream();
    test_send_over_stream();
    test_full();
    test_kill();
    test_incept_while_active();
    test_enable_low();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
